fp_issue_ctrl: RTL

Operand-issue controller that sits upstream of the fp_13 floating-point add/sub unit. It buffers add/sub requests in a small FIFO and issues them one at a time to the FPU, driving `flag_i`, `op`, `a` and `b` toward the FPU. It waits for `flag_o`, captures `c`, and presents tagged results on a valid/ready output port. It is the initiator side of the FPU's flag_i/flag_o interface.

---
 rtl/fp_issue_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl
// Operand-issue controller for the fp_13 add/sub unit. Requests are queued
// in a small FIFO and issued one at a time over the flag_i/flag_o handshake.
// Tagged results are returned on a valid/ready port. Operands and results
// pass through bit-exact, and NaN/Inf are never interpreted.
// Build option: define FP_ISSUE_TIMEOUT_EN to add a WAIT watchdog. If the
// FPU stays silent for TIMEOUT cycles, the watchdog returns qNaN with
// res_err set.

module fp_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             fpu_flag_i,
    output logic             fpu_op,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic [31:0]      fpu_c,
    input  logic             fpu_flag_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_c,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]       QNAN     = 32'h7fc00000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic [TAG_W-1:0] tag_q;
    logic             opMem_q  [DEPTH];
    logic [31:0]      aMem_q   [DEPTH];
    logic [31:0]      bMem_q   [DEPTH];
    logic [TAG_W-1:0] tagMem_q [DEPTH];

    logic             fpuFlag_q, fpuOp_q;
    logic [31:0]      fpuA_q, fpuB_q;
    logic [TAG_W-1:0] issTag_q;
    logic             resValid_q;
    logic [31:0]      resC_q;
    logic [TAG_W-1:0] resTag_q;

    logic fifoEmpty, push, pop, bypass, fifoWrite, timeoutHit;

    // An empty FIFO in IDLE hands a fresh request straight to the operand
    // registers. This lets the request reach ISSUE in the cycle right after
    // it is accepted.
    assign req_ready = (count_q != FULL_CNT);
    assign fifoEmpty = (count_q == '0);
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == IDLE) && !fifoEmpty;
    assign bypass    = (state_q == IDLE) && fifoEmpty && push;
    assign fifoWrite = push && !bypass;

    // FIFO pointers, occupancy and the per-push sequence tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            tag_q   <= '0;
        end else begin
            if (fifoWrite) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)       rdPtr_q <= rdPtr_q + 1'b1;
            if (push)      tag_q   <= tag_q + 1'b1;
            if (fifoWrite && !pop)      count_q <= count_q + 1'b1;
            else if (!fifoWrite && pop) count_q <= count_q - 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (fifoWrite) begin
            opMem_q[wrPtr_q]  <= req_op;
            aMem_q[wrPtr_q]   <= req_a;
            bMem_q[wrPtr_q]   <= req_b;
            tagMem_q[wrPtr_q] <= tag_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flag_o only matters while waiting in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop || bypass) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (fpu_flag_o || timeoutHit) state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand registers load on the pop and stay frozen until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpuFlag_q <= 1'b0;
            fpuOp_q   <= 1'b0;
            fpuA_q    <= '0;
            fpuB_q    <= '0;
            issTag_q  <= '0;
        end else begin
            fpuFlag_q <= (state_d == ISSUE);
            if (pop) begin
                fpuOp_q  <= opMem_q[rdPtr_q];
                fpuA_q   <= aMem_q[rdPtr_q];
                fpuB_q   <= bMem_q[rdPtr_q];
                issTag_q <= tagMem_q[rdPtr_q];
            end else if (bypass) begin
                fpuOp_q  <= req_op;
                fpuA_q   <= req_a;
                fpuB_q   <= req_b;
                issTag_q <= tag_q;
            end
        end
    end

    // Result register: captured in WAIT, held through HOLD until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            resValid_q <= 1'b0;
            resC_q     <= '0;
            resTag_q   <= '0;
        end else if (state_q == WAIT && fpu_flag_o) begin
            resValid_q <= 1'b1;
            resC_q     <= fpu_c;
            resTag_q   <= issTag_q;
        end else if (timeoutHit) begin
            resValid_q <= 1'b1;
            resC_q     <= QNAN;
            resTag_q   <= issTag_q;
        end else if (state_q == HOLD && res_ready) begin
            resValid_q <= 1'b0;
        end
    end

`ifdef FP_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] waitCnt_q;
    logic             resErr_q;

    // WAIT-cycle counter, cleared in ISSUE.
    // It fires on the TIMEOUT-th silent WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst)                  waitCnt_q <= '0;
        else if (state_q == ISSUE) waitCnt_q <= '0;
        else if (state_q == WAIT)  waitCnt_q <= waitCnt_q + 1'b1;
    end

    assign timeoutHit = (state_q == WAIT) && !fpu_flag_o && (waitCnt_q == CNT_W'(TIMEOUT - 1));

    // Error flag: a real flag_o always wins over a coincident timeout.
    always_ff @(posedge clk) begin
        if (rst)                                  resErr_q <= 1'b0;
        else if (state_q == WAIT && fpu_flag_o)   resErr_q <= 1'b0;
        else if (timeoutHit)                      resErr_q <= 1'b1;
    end

    assign res_err = resErr_q;
`else
    assign timeoutHit = 1'b0;
    assign res_err    = 1'b0;
`endif

    assign fpu_flag_i = fpuFlag_q;
    assign fpu_op     = fpuOp_q;
    assign fpu_a      = fpuA_q;
    assign fpu_b      = fpuB_q;
    assign res_valid  = resValid_q;
    assign res_c      = resC_q;
    assign res_tag    = resTag_q;

endmodule
